// File: rtl/gyro_pkg.sv
// Shared types and helpers for the multi-axis gyro integrator.
package gyro_pkg;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        CAL
    } gyro_state_t;

    function automatic int unsigned acc_w(input int unsigned angle_w,
                                          input int unsigned frac_bits);
        return angle_w + frac_bits;
    endfunction

endpackage

// File: rtl/angle_wrap_add.sv
// Combinational modular add: acc_next = (acc + d) mod MOD, for acc in [0, MOD) and |d| <= MOD.
module angle_wrap_add #(
    parameter int unsigned ACC_W = 17,
    parameter int unsigned D_W   = 17,
    parameter int unsigned MOD   = 92160
) (
    input  logic [ACC_W-1:0]        acc,
    input  logic signed [D_W-1:0]   d,
    output logic [ACC_W-1:0]        acc_next
);

    localparam int unsigned S_W = ACC_W + 2;
    localparam logic signed [S_W-1:0] MOD_S = S_W'(MOD);

    logic signed [S_W-1:0] s;
    logic signed [S_W-1:0] s_mod;

    always_comb begin
        s = $signed({2'b00, acc}) + S_W'(d);
        if (s >= MOD_S) begin
            s_mod = s - MOD_S;
        end else if (s < 0) begin
            s_mod = s + MOD_S;
        end else begin
            s_mod = s;
        end
        acc_next = s_mod[ACC_W-1:0];
    end

endmodule

// File: rtl/gyro_integrator.sv
// Integrates per-axis signed rate samples into wrapped angles on a fixed tick, with
// on-demand bias calibration and a synchronous zero command.
module gyro_integrator
    import gyro_pkg::*;
#(
    parameter int unsigned NUM_AXES    = 3,
    parameter int unsigned RATE_W      = 16,
    parameter int unsigned ANGLE_W     = 9,
    parameter int unsigned FRAC_BITS   = 8,
    parameter int unsigned FULL_SCALE  = 360,
    parameter int unsigned TICK_CYCLES = 100_000,
    parameter int unsigned CAL_LOG2    = 4
) (
    input  logic                          clk_100mhz,
    input  logic                          rst_n_in,
    input  logic [NUM_AXES*RATE_W-1:0]    rate_in,
    input  logic                          rate_valid_in,
    input  logic                          cal_start_in,
    input  logic                          zero_in,
    output logic [NUM_AXES*ANGLE_W-1:0]   angle_out,
    output logic                          angle_valid_out,
    output logic                          calibrating_out
);

    localparam int unsigned ACC_W  = acc_w(ANGLE_W, FRAC_BITS);
    localparam int unsigned M      = FULL_SCALE * (2 ** FRAC_BITS);
    localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int unsigned IDX_W  = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
    localparam int unsigned SUM_W  = RATE_W + CAL_LOG2;

    if ((longint'(1) << RATE_W) > longint'(M)) begin : g_bad_range
        $error("gyro_integrator: 2**RATE_W must not exceed FULL_SCALE*2**FRAC_BITS");
    end
    if (TICK_CYCLES <= NUM_AXES + 2) begin : g_bad_tick
        $error("gyro_integrator: TICK_CYCLES must exceed NUM_AXES+2");
    end
    if (CAL_LOG2 < 1) begin : g_bad_cal
        $error("gyro_integrator: CAL_LOG2 must be at least 1");
    end

    gyro_state_t                 state;
    logic [TICK_W-1:0]           tick_cnt;
    logic                        tick;
    logic [IDX_W-1:0]            idx;
    logic                        cal_pending;
    logic [CAL_LOG2-1:0]         cal_cnt;
    logic signed [RATE_W-1:0]    rate_hold [NUM_AXES];
    logic signed [RATE_W-1:0]    bias      [NUM_AXES];
    logic [ACC_W-1:0]            acc       [NUM_AXES];
    logic signed [SUM_W-1:0]     cal_sum   [NUM_AXES];
    logic signed [SUM_W-1:0]     cal_next  [NUM_AXES];
    logic signed [RATE_W-1:0]    cal_avg   [NUM_AXES];

    logic [ACC_W-1:0]            sel_acc;
    logic signed [RATE_W:0]      sel_d;
    logic [ACC_W-1:0]            acc_new;

    assign tick = (tick_cnt == TICK_W'(TICK_CYCLES - 1));

    // One shared wrap adder, time-multiplexed across axes by idx.
    always_comb begin
        sel_acc = acc[idx];
        sel_d   = {rate_hold[idx][RATE_W-1], rate_hold[idx]}
                - {bias[idx][RATE_W-1], bias[idx]};
    end

    angle_wrap_add #(
        .ACC_W (ACC_W),
        .D_W   (RATE_W + 1),
        .MOD   (M)
    ) u_wrap (
        .acc      (sel_acc),
        .d        (sel_d),
        .acc_next (acc_new)
    );

    always_comb begin
        for (int k = 0; k < NUM_AXES; k++) begin
            cal_next[k] = cal_sum[k] + SUM_W'($signed(rate_in[k*RATE_W +: RATE_W]));
            cal_avg[k]  = RATE_W'(cal_next[k] >>> CAL_LOG2);
        end
    end

    for (genvar k = 0; k < NUM_AXES; k++) begin : g_out
        assign angle_out[k*ANGLE_W +: ANGLE_W] = acc[k][ACC_W-1:FRAC_BITS];
    end

    always_ff @(posedge clk_100mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= IDLE;
            tick_cnt        <= '0;
            idx             <= '0;
            cal_pending     <= 1'b0;
            cal_cnt         <= '0;
            angle_valid_out <= 1'b0;
            calibrating_out <= 1'b0;
            for (int k = 0; k < NUM_AXES; k++) begin
                rate_hold[k] <= '0;
                bias[k]      <= '0;
                acc[k]       <= '0;
                cal_sum[k]   <= '0;
            end
        end else begin
            tick_cnt        <= tick ? '0 : tick_cnt + 1'b1;
            angle_valid_out <= 1'b0;
            for (int k = 0; k < NUM_AXES; k++) begin
                if (rate_valid_in) begin
                    rate_hold[k] <= rate_in[k*RATE_W +: RATE_W];
                end
            end

            case (state)
                IDLE: begin
                    if (cal_start_in || cal_pending) begin
                        state           <= CAL;
                        calibrating_out <= 1'b1;
                        cal_pending     <= 1'b0;
                        cal_cnt         <= '0;
                        for (int k = 0; k < NUM_AXES; k++) begin
                            cal_sum[k] <= '0;
                        end
                    end else if (tick && !zero_in) begin
                        state <= UPDATE;
                        idx   <= '0;
                    end
                end
                UPDATE: begin
                    if (cal_start_in) begin
                        cal_pending <= 1'b1;
                    end
                    if (zero_in) begin
                        state <= IDLE;
                    end else begin
                        acc[idx] <= acc_new;
                        if (idx == IDX_W'(NUM_AXES - 1)) begin
                            state           <= IDLE;
                            angle_valid_out <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                CAL: begin
                    if (rate_valid_in) begin
                        cal_cnt <= cal_cnt + 1'b1;
                        for (int k = 0; k < NUM_AXES; k++) begin
                            cal_sum[k] <= cal_next[k];
                        end
                        if (cal_cnt == {CAL_LOG2{1'b1}}) begin
                            state           <= IDLE;
                            calibrating_out <= 1'b0;
                            for (int k = 0; k < NUM_AXES; k++) begin
                                bias[k] <= cal_avg[k];
                                acc[k]  <= '0;
                            end
                        end
                    end
                end
                default: begin
                    state           <= IDLE;
                    calibrating_out <= 1'b0;
                end
            endcase

            // Zero overrides any accumulator write made above in the same cycle.
            if (zero_in) begin
                for (int k = 0; k < NUM_AXES; k++) begin
                    acc[k] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gyro_integrator.sv
// Scoreboard bench for gyro_integrator: expected strobe angles are queued by the stimulus
// and popped by an independent monitor on every angle_valid_out.
module tb_gyro_integrator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] rate_in = '0;
    logic        rate_valid = 1'b1;
    logic        cal_start = 1'b0;
    logic        zero = 1'b0;
    logic [26:0] angle_out;
    logic        angle_valid;
    logic        calibrating;

    int checks = 0;
    int errors = 0;
    logic [26:0] exp_q[$];

    gyro_integrator #(
        .TICK_CYCLES (10)
    ) dut (
        .clk_100mhz      (clk),
        .rst_n_in        (rst_n),
        .rate_in         (rate_in),
        .rate_valid_in   (rate_valid),
        .cal_start_in    (cal_start),
        .zero_in         (zero),
        .angle_out       (angle_out),
        .angle_valid_out (angle_valid),
        .calibrating_out (calibrating)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [26:0] vec3(input int a, input int b, input int c);
        return {9'(c), 9'(b), 9'(a)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && angle_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got 0x%0h expected no strobe", angle_out);
            end else begin
                logic [26:0] e;
                e = exp_q.pop_front();
                if (angle_out !== e) begin
                    errors++;
                    $display("FAIL strobe_angles: got 0x%0h expected 0x%0h", angle_out, e);
                end
            end
        end
    end

    task automatic set_rates(input logic signed [15:0] a, input logic signed [15:0] b,
                             input logic signed [15:0] c);
        rate_in = {c, b, a};
    endtask

    // Returns number of negedges seen up to and including the strobe.
    task automatic wait_strobe(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!angle_valid && n < budget);
        if (!angle_valid) begin
            checks++;
            errors++;
            $display("FAIL strobe_timeout: got none after %0d cycles expected a strobe", n);
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cal_start = 1'b0;
        zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_angles", angle_out, 0);
        check("reset_valid", angle_valid, 0);
        check("reset_cal", calibrating, 0);
        rst_n = 1'b1;
    endtask

    task automatic pulse_cal();
        @(posedge clk); #1 cal_start = 1'b1;
        @(posedge clk); #1 cal_start = 1'b0;
    endtask

    task automatic wait_cal_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            if (calibrating) n++;
        end while (calibrating && n < 60);
    endtask

    task automatic drain(input string name);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int n;

        // Steady rate: +1 per tick on every axis, strobe 4 cycles after each tick.
        set_rates(256, 256, 256);
        do_reset();
        for (int i = 1; i <= 10; i++) exp_q.push_back(vec3(i, i, i));
        wait_strobe(40, n);
        check("first_strobe_latency", n, 14);
        for (int i = 2; i <= 10; i++) begin
            wait_strobe(20, n);
            check("strobe_period", n, 10);
        end
        drain("steady_drain");

        // Wrap up on axis 0, wrap down on axis 1, plain on axis 2.
        set_rates(25600, -256, 256);
        do_reset();
        exp_q.push_back(vec3(100, 359, 1));
        exp_q.push_back(vec3(200, 358, 2));
        exp_q.push_back(vec3(300, 357, 3));
        exp_q.push_back(vec3(40, 356, 4));
        repeat (4) wait_strobe(40, n);
        drain("wrap_drain");

        // Calibration at +300: angles clear, d becomes 0, then 556 gives +1 per tick.
        set_rates(300, 300, 300);
        do_reset();
        exp_q.push_back(vec3(1, 1, 1));
        wait_strobe(40, n);
        pulse_cal();
        check("cal_enter", calibrating, 1);
        wait_cal_done(n);
        check("cal_cycles", n, 16);
        check("cal_angles_zero", angle_out, 0);
        exp_q.push_back(vec3(0, 0, 0));
        wait_strobe(40, n);
        set_rates(556, 556, 556);
        exp_q.push_back(vec3(1, 1, 1));
        exp_q.push_back(vec3(2, 2, 2));
        repeat (2) wait_strobe(20, n);
        drain("cal_pos_drain");

        // Calibration at -5: bias must come out as -5 (arithmetic shift).
        set_rates(-5, -5, -5);
        do_reset();
        exp_q.push_back(vec3(359, 359, 359));
        wait_strobe(40, n);
        pulse_cal();
        wait_cal_done(n);
        check("cal_neg_angles_zero", angle_out, 0);
        exp_q.push_back(vec3(0, 0, 0));
        wait_strobe(40, n);
        set_rates(251, 251, 251);
        exp_q.push_back(vec3(1, 1, 1));
        wait_strobe(20, n);
        drain("cal_neg_drain");

        // Zero coincident with tick: that tick is skipped.
        set_rates(256, 256, 256);
        do_reset();
        exp_q.push_back(vec3(1, 1, 1));
        wait_strobe(40, n);
        repeat (6) @(posedge clk);
        #1 zero = 1'b1;
        @(posedge clk); #1 zero = 1'b0;
        check("zero_tick_angles", angle_out, 0);
        exp_q.push_back(vec3(1, 1, 1));
        wait_strobe(40, n);
        check("zero_tick_skip", n, 14);

        // Zero while updating axis 1: update aborted, no strobe.
        repeat (8) @(posedge clk);
        #1 zero = 1'b1;
        @(posedge clk); #1 zero = 1'b0;
        check("zero_upd_angles", angle_out, 0);
        exp_q.push_back(vec3(1, 1, 1));
        wait_strobe(40, n);
        check("zero_upd_skip", n, 12);

        // Calibration request mid-update: strobe completes, then CAL.
        exp_q.push_back(vec3(2, 2, 2));
        repeat (8) @(posedge clk);
        #1 cal_start = 1'b1;
        @(posedge clk); #1 cal_start = 1'b0;
        check("pending_not_cal_yet", calibrating, 0);
        wait_strobe(10, n);
        @(negedge clk);
        check("pending_enters_cal", calibrating, 1);
        wait_cal_done(n);
        check("pending_cal_angles", angle_out, 0);
        drain("pending_drain");

        // Reset mid-update clears outputs at once; integration resumes from zero.
        set_rates(256, 256, 256);
        do_reset();
        exp_q.push_back(vec3(1, 1, 1));
        wait_strobe(40, n);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_upd_angles", angle_out, 0);
        check("rst_upd_valid", angle_valid, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        exp_q.push_back(vec3(1, 1, 1));
        exp_q.push_back(vec3(2, 2, 2));
        wait_strobe(40, n);
        check("rst_upd_resume_latency", n, 14);
        wait_strobe(20, n);

        // Reset mid-calibration: CAL abandoned, bias stays 0.
        pulse_cal();
        repeat (5) @(posedge clk);
        #1;
        check("rst_cal_in_cal", calibrating, 1);
        rst_n = 1'b0;
        #1;
        check("rst_cal_flag", calibrating, 0);
        check("rst_cal_angles", angle_out, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        exp_q.push_back(vec3(1, 1, 1));
        wait_strobe(40, n);
        drain("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gyro_integrator.md
# gyro_integrator

Parametrised multi-axis gyro integrator, successor to `process_gyro_simple`. It converts signed angular-rate samples from the IMU reader into wrapped angles, one per axis, on a fixed integration tick derived from `clk_100mhz`. It adds on-demand bias calibration, a synchronous zero command, and a per-tick valid strobe. Its outputs feed the orientation and render logic.

## Interface
Parameters:
- `NUM_AXES`, 3: number of axes. Index 0/1/2 = pitch/roll/yaw.
- `RATE_W`, 16: signed rate sample width.
- `ANGLE_W`, 9: integer angle output width.
- `FRAC_BITS`, 8: accumulator fractional bits. A rate of 2^FRAC_BITS gives 1 unit per tick.
- `FULL_SCALE`, 360: wrap modulus in angle units.
- `TICK_CYCLES`, 100_000: clock cycles per integration tick. Must be > NUM_AXES+2.
- `CAL_LOG2`, 4: calibration averages 2^CAL_LOG2 samples per axis.

Ports:
- `clk_100mhz` in 1: the single clock.
- `rst_n_in` in 1: asynchronous, active-low reset.
- `rate_in` in NUM_AXES×RATE_W: packed, signed per axis.
- `rate_valid_in` in 1: qualifies `rate_in`.
- `cal_start_in` in 1: single-cycle pulse that requests calibration.
- `zero_in` in 1: single-cycle pulse that clears all angles.
- `angle_out` out NUM_AXES×ANGLE_W: per-axis angle, range 0..FULL_SCALE-1.
- `angle_valid_out` out 1: one-cycle strobe; all angles updated.
- `calibrating_out` out 1: high while in CAL.

## Operation
- **Rate hold:** `rate_hold[k]` latches `rate_in[k]` on every cycle with `rate_valid_in`. Integration uses the held value (zero-order hold). Reset value is 0.
- **Tick counter:** counts 0..TICK_CYCLES-1 and wraps. `tick` is high when count = TICK_CYCLES-1. The counter runs in all states.
- **Accumulator:** `acc[k]` is unsigned, ACC_W = ANGLE_W+FRAC_BITS bits, invariant 0 ≤ acc < M where M = FULL_SCALE·2^FRAC_BITS.
- **Update step for axis k:**
  - d = rate_hold[k] − bias[k], signed, RATE_W+1 bits.
  - s = acc + d, signed, ACC_W+2 bits.
  - If s ≥ M then acc = s − M; else if s < 0 then acc = s + M; else acc = s.
  - Elaboration-time check: 2^RATE_W ≤ M, so a single correction always suffices.
- **Output:** `angle_out[k]` = acc[k] >> FRAC_BITS, registered.
- **FSM states:**
  - IDLE: on `tick`, go to UPDATE with idx=0.
  - UPDATE: process axis idx, one axis per cycle. After idx = NUM_AXES-1, pulse `angle_valid_out` and go to IDLE.
  - CAL: on each `rate_valid_in`, add sign-extended `rate_in[k]` into `cal_sum[k]` (RATE_W+CAL_LOG2 bits) and increment `cal_cnt`. When the 2^CAL_LOG2-th sample is summed, set bias[k] = cal_sum[k] >>> CAL_LOG2, clear all acc to 0, and go to IDLE. Ticks are ignored in CAL.
- **`cal_start_in`:**
  - In IDLE: enter CAL next cycle, clearing `cal_sum` and `cal_cnt`.
  - In UPDATE: latch as pending. Enter CAL after the update completes, after `angle_valid_out`.
  - In CAL: ignored.
- **`zero_in`:** clears all acc on the next edge in any state.
  - In UPDATE it aborts the update: no `angle_valid_out`, go to IDLE.
  - In CAL, calibration continues.
  - If it coincides with `tick` in IDLE, zero wins and that tick is skipped.
- **Reset values:** state=IDLE, acc=0, bias=0, angle_out=0, angle_valid_out=0, calibrating_out=0, counters=0, pending=0. Reset asserted mid-UPDATE or mid-CAL discards all progress.

## Timing
- `tick` at cycle T: axis k's acc and angle_out update on edge T+1+k.
- `angle_valid_out` is high in cycle T+NUM_AXES+1. All `angle_out` values are stable from then until the next update.
- Zero/cal effects are visible one cycle after the input pulse.
- `calibrating_out` is registered and equals (state==CAL).
- Cal completion: bias and acc change on the edge that accepts the final sample. `calibrating_out` falls in the same cycle.
- Throughput: one update per TICK_CYCLES. No backpressure.

## Structure
- Package `gyro_pkg`:
  - `gyro_state_t` enum {IDLE, UPDATE, CAL}.
  - Helper function `acc_w(ANGLE_W, FRAC_BITS)`.
- Sub-module `angle_wrap_add`: combinational modular add (acc, d, M) → acc'. It is shared by all axes through the idx mux.
- Top level holds the tick counter, FSM, and register arrays.

## Test plan
Bench uses TICK_CYCLES=10 and other parameters at default.
- **Steady rate:** reset, all rates 256 valid → after 10 strobes, angles = 10,10,10. Each strobe comes 4 cycles after its tick.
- **Wrap up:** rate 25600 (100/tick) → strobes read 100,200,300,40.
- **Wrap down:** rate −256 from zero → first strobe 359, then 358.
- **Calibration:**
  - Rates held at 300.
  - Pulse `cal_start_in` → `calibrating_out` high for 16 valid samples, bias=300, angles=0.
  - Then rate 556 → +1 per strobe.
  - Negative case: rates held at −5 → bias = −5, from arithmetic shift.
- **Zero collisions:**
  - `zero_in` coincident with `tick` → no strobe that tick, angles 0.
  - `zero_in` at UPDATE idx=1 → no strobe, all 0.
  - `cal_start_in` during UPDATE → strobe, then CAL.
- **Reset mid-op:** deassert `rst_n_in` during UPDATE and during CAL → all outputs 0 immediately. Normal integration resumes after release.
